// File: rtl/interrupt_controller.sv
// Interrupt controller: synchronises device lines, latches rising edges, arbitrates
// by fixed lowest-index priority and runs the permit/request/service handshake with CP0.
module interrupt_controller #(
  parameter int N_IRQ      = 8,
  parameter int IRQ_BASE   = 0,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IRQ-1:0]      irq,
  output logic [4:0]            int_device,
  input  logic                  int_permit,
  output logic                  int_req,
  output logic [DATA_WIDTH-1:0] int_cause,
  input  logic                  int_ack,
  input  logic                  eoi,
  output logic [N_IRQ-1:0]      pending,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Handshakes: int_device is offered to CP0 from PERMIT until int_permit is seen high;
  // int_req then stays high, never withdrawn, until a single-cycle int_ack is sampled in REQ.
  typedef enum logic [1:0] {S_IDLE, S_PERMIT, S_REQ, S_SERVICE} state_t;

  localparam logic [N_IRQ-1:0] LINE0 = N_IRQ'(1);

  state_t                  state_q;
  logic [N_IRQ-1:0]        sync1_q, sync2_q, prev_q;
  logic [N_IRQ-1:0]        pending_q, pending_d;
  logic [N_IRQ-1:0]        rise, clr_mask;
  logic [4:0]              sel_q, pri_idx;
  logic [4:0]              int_device_q;
  logic                    int_req_q, busy_q;
  logic [DATA_WIDTH-1:0]   int_cause_q;

  function automatic logic [4:0] first_set(input logic [N_IRQ-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (v[k]) idx = 5'(k);
    end
    return idx;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] make_cause(input logic [4:0] id);
    logic [DATA_WIDTH-1:0] c;
    c                 = '0;
    c[DATA_WIDTH-1]   = 1'b1;
    c[4:0]            = id;
    return c;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= irq;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // A new edge on the line being acknowledged must survive the clear.
  always_comb begin
    rise     = sync2_q & ~prev_q;
    clr_mask = '0;
    if (state_q == S_REQ && int_ack) clr_mask = LINE0 << sel_q;
    pending_d = (pending_q & ~clr_mask) | rise;
    pri_idx   = first_set(pending_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      int_device_q <= '0;
      int_req_q    <= 1'b0;
      busy_q       <= 1'b0;
      int_cause_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|pending_q) begin
            sel_q        <= pri_idx;
            int_device_q <= 5'(IRQ_BASE) + pri_idx;
            state_q      <= S_PERMIT;
          end
        end
        S_PERMIT: begin
          if (int_permit) begin
            state_q     <= S_REQ;
            int_req_q   <= 1'b1;
            busy_q      <= 1'b1;
            int_cause_q <= make_cause(int_device_q);
          end else begin
            // pending[sel] is still set here, so pri_idx can only move to a higher priority.
            sel_q        <= pri_idx;
            int_device_q <= 5'(IRQ_BASE) + pri_idx;
          end
        end
        S_REQ: begin
          if (int_ack) begin
            state_q     <= S_SERVICE;
            int_req_q   <= 1'b0;
            int_cause_q <= '0;
          end
        end
        S_SERVICE: begin
          if (eoi) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign int_device = int_device_q;
  assign int_req    = int_req_q;
  assign int_cause  = int_cause_q;
  assign pending    = pending_q;
  assign busy       = busy_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus randomized traffic against a
// behavioural model; a second instance with IRQ_BASE=8 shares all inputs.
module tb_interrupt_controller;

  localparam int P_IDLE = 0, P_OFFER = 1, P_REQUEST = 2, P_SERVICE = 3;

  logic        clk, rst;
  logic [7:0]  irq;
  logic        int_permit, int_ack, eoi;
  logic [4:0]  dev0, dev8;
  logic        req0, req8, busy0, busy8;
  logic [31:0] cause0, cause8;
  logic [7:0]  pend0, pend8;
  logic [1:0]  st0, st8;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state
  int          phase;
  int          sel_m;
  bit          seen_m;
  logic [7:0]  pend_m;
  logic [7:0]  smp[$];

  interrupt_controller #(.N_IRQ(8), .IRQ_BASE(0), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .irq(irq), .int_device(dev0), .int_permit(int_permit),
    .int_req(req0), .int_cause(cause0), .int_ack(int_ack), .eoi(eoi),
    .pending(pend0), .busy(busy0), .dbg_state(st0)
  );

  interrupt_controller #(.N_IRQ(8), .IRQ_BASE(8), .DATA_WIDTH(32)) dut8 (
    .clk(clk), .rst(rst), .irq(irq), .int_device(dev8), .int_permit(int_permit),
    .int_req(req8), .int_cause(cause8), .int_ack(int_ack), .eoi(eoi),
    .pending(pend8), .busy(busy8), .dbg_state(st8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lowest(input logic [7:0] v);
    for (int k = 0; k < 8; k++) if (v[k]) return k;
    return 0;
  endfunction

  function automatic logic [31:0] exp_cause(input int base);
    return (phase == P_REQUEST) ? (32'h8000_0000 | 32'(base + sel_m)) : 32'h0;
  endfunction

  function automatic logic [4:0] exp_dev(input int base);
    return seen_m ? 5'(base + sel_m) : 5'd0;
  endfunction

  task automatic model_reset();
    phase  = P_IDLE;
    sel_m  = 0;
    seen_m = 1'b0;
    pend_m = 8'h00;
    smp.delete();
    repeat (3) smp.push_back(8'h00);
  endtask

  // An edge is seen when irq was high two edges ago and low three edges ago.
  task automatic step();
    logic [7:0] ev, clr;
    int last;
    @(posedge clk);
    smp.push_back(irq);
    last = smp.size() - 1;
    ev   = smp[last-2] & ~smp[last-3];
    clr  = 8'h00;
    case (phase)
      P_IDLE:    if (pend_m != 0) begin sel_m = lowest(pend_m); seen_m = 1'b1; phase = P_OFFER; end
      P_OFFER:   if (int_permit) phase = P_REQUEST;
                 else sel_m = lowest(pend_m);
      P_REQUEST: if (int_ack) begin clr = 8'h01 << sel_m; phase = P_SERVICE; end
      default:   if (eoi) phase = P_IDLE;
    endcase
    pend_m = (pend_m & ~clr) | ev;
    void'(smp.pop_front());
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b0; irq = 8'h00; int_permit = 1'b0; int_ack = 1'b0; eoi = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    rst = 1'b1;
  endtask

  task automatic pulse_irq(input logic [7:0] bits);
    irq = bits; step(); irq = 8'h00;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (req0 !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b exp 0", req0); end
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy0); end
    n_tests++; if (pend0 !== 8'h00) begin n_fail++; $display("FAIL reset_pend got %h exp 00", pend0); end
    n_tests++; if (cause0 !== 32'h0) begin n_fail++; $display("FAIL reset_cause got %h exp 0", cause0); end
    n_tests++; if (dev8 !== 5'd0) begin n_fail++; $display("FAIL reset_dev8 got %0d exp 0", dev8); end
  endtask

  task automatic test_single();
    do_reset();
    int_permit = 1'b1;
    pulse_irq(8'h04); steps(2);
    n_tests++; if (pend0 !== 8'h04) begin n_fail++; $display("FAIL single_pend got %h exp 04", pend0); end
    steps(2);
    n_tests++; if (dev0 !== 5'd2) begin n_fail++; $display("FAIL single_dev got %0d exp 2", dev0); end
    n_tests++; if (req0 !== 1'b1) begin n_fail++; $display("FAIL single_req got %b exp 1", req0); end
    n_tests++; if (cause0 !== 32'h8000_0002) begin n_fail++; $display("FAIL single_cause got %h exp 80000002", cause0); end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    n_tests++; if (pend0 !== 8'h00) begin n_fail++; $display("FAIL single_ackpend got %h exp 00", pend0); end
    n_tests++; if (req0 !== 1'b0 || cause0 !== 32'h0) begin n_fail++; $display("FAIL single_ackreq got %b/%h exp 0/0", req0, cause0); end
    steps(4);
    n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL single_busy got %b exp 1", busy0); end
    eoi = 1'b1; step(); eoi = 1'b0;
    n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL single_eoi got %b exp 0", busy0); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    int_permit = 1'b1;
    pulse_irq(8'h22); steps(2);
    n_tests++; if (pend0 !== 8'h22) begin n_fail++; $display("FAIL simul_pend got %h exp 22", pend0); end
    steps(2);
    n_tests++; if (req0 !== 1'b1 || dev0 !== 5'd1) begin n_fail++; $display("FAIL simul_first got req %b id %0d exp 1/1", req0, dev0); end
    int_ack = 1'b1; step(); int_ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;
    steps(2);
    n_tests++; if (req0 !== 1'b1 || cause0 !== 32'h8000_0005) begin n_fail++; $display("FAIL simul_second got req %b cause %h exp 1/80000005", req0, cause0); end
  endtask

  task automatic test_permit_hold();
    do_reset();
    pulse_irq(8'h10); steps(5);
    n_tests++; if (req0 !== 1'b0 || dev0 !== 5'd4) begin n_fail++; $display("FAIL hold_wait got req %b id %0d exp 0/4", req0, dev0); end
    pulse_irq(8'h01); steps(3);
    n_tests++; if (dev0 !== 5'd0 || req0 !== 1'b0) begin n_fail++; $display("FAIL hold_switch got id %0d req %b exp 0/0", dev0, req0); end
    int_permit = 1'b1; step();
    n_tests++; if (req0 !== 1'b1 || cause0 !== 32'h8000_0000) begin n_fail++; $display("FAIL hold_req got req %b cause %h exp 1/80000000", req0, cause0); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    int_permit = 1'b1;
    pulse_irq(8'h08); steps(4);
    int_permit = 1'b0; steps(3);
    n_tests++; if (req0 !== 1'b1 || dev0 !== 5'd3) begin n_fail++; $display("FAIL b2b_held got req %b id %0d exp 1/3", req0, dev0); end
    pulse_irq(8'h08); step();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    n_tests++; if (pend0 !== 8'h08) begin n_fail++; $display("FAIL b2b_setwins got %h exp 08", pend0); end
    n_tests++; if (req0 !== 1'b0 || busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_service got req %b busy %b exp 0/1", req0, busy0); end
  endtask

  task automatic test_irq_base();
    do_reset();
    int_permit = 1'b1;
    pulse_irq(8'h01); steps(4);
    n_tests++; if (dev8 !== 5'd8) begin n_fail++; $display("FAIL base_dev got %0d exp 8", dev8); end
    n_tests++; if (cause8 !== 32'h8000_0008) begin n_fail++; $display("FAIL base_cause got %h exp 80000008", cause8); end
  endtask

  task automatic test_async_reset();
    do_reset();
    int_permit = 1'b1;
    pulse_irq(8'h40); steps(4);
    n_tests++; if (req0 !== 1'b1) begin n_fail++; $display("FAIL areset_pre got %b exp 1", req0); end
    #3 rst = 1'b0;
    #1;
    n_tests++; if (req0 !== 1'b0 || busy0 !== 1'b0 || pend0 !== 8'h00) begin n_fail++; $display("FAIL areset_drop got req %b busy %b pend %h exp 0/0/00", req0, busy0, pend0); end
    n_tests++; if (req8 !== 1'b0 || dev8 !== 5'd0) begin n_fail++; $display("FAIL areset_drop8 got req %b id %0d exp 0/0", req8, dev8); end
    model_reset();
    #2 rst = 1'b1;
    steps(6);
    n_tests++; if (req0 !== 1'b0 || busy0 !== 1'b0 || pend0 !== 8'h00) begin n_fail++; $display("FAIL areset_quiet got req %b busy %b pend %h exp 0/0/00", req0, busy0, pend0); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      irq        = irq ^ (8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)));
      int_permit = ($urandom_range(0, 9) < 6);
      int_ack    = ($urandom_range(0, 3) == 0);
      eoi        = ($urandom_range(0, 4) == 0);
      step();
      n_tests++; if (pend0 !== pend_m) begin n_fail++; $display("FAIL rnd_pend cyc %0d got %h exp %h", c, pend0, pend_m); end
      n_tests++; if (req0 !== (phase == P_REQUEST)) begin n_fail++; $display("FAIL rnd_req cyc %0d got %b exp %b", c, req0, phase == P_REQUEST); end
      n_tests++; if (busy0 !== (phase >= P_REQUEST)) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %b exp %b", c, busy0, phase >= P_REQUEST); end
      n_tests++; if (dev0 !== exp_dev(0)) begin n_fail++; $display("FAIL rnd_dev cyc %0d got %0d exp %0d", c, dev0, exp_dev(0)); end
      n_tests++; if (cause0 !== exp_cause(0)) begin n_fail++; $display("FAIL rnd_cause cyc %0d got %h exp %h", c, cause0, exp_cause(0)); end
      n_tests++; if (dev8 !== exp_dev(8)) begin n_fail++; $display("FAIL rnd_dev8 cyc %0d got %0d exp %0d", c, dev8, exp_dev(8)); end
      n_tests++; if (cause8 !== exp_cause(8)) begin n_fail++; $display("FAIL rnd_cause8 cyc %0d got %h exp %h", c, cause8, exp_cause(8)); end
    end
    int_ack = 1'b0; eoi = 1'b0; irq = 8'h00;
  endtask

  initial begin
    rst = 1'b0; irq = 8'h00; int_permit = 1'b0; int_ack = 1'b0; eoi = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_simultaneous();
    test_permit_hold();
    test_back_to_back();
    test_irq_base();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
